// File: rtl/video_src_sched.sv
// Per-frame pixel source scheduler: picks colour bars, a FIFO stream or a solid colour
// for each requested pixel, and substitutes a fill colour when the stream runs dry.
module video_src_sched #(
  parameter int unsigned H_DISP   = 3840,
  parameter int unsigned V_DISP   = 2160,
  parameter logic [23:0] FILL_RGB = 24'h0000FF
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        data_req,
  input  logic [12:0] pixel_xpos,
  input  logic [12:0] pixel_ypos,
  input  logic        video_vs,
  input  logic [1:0]  src_sel,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] strm_data,
  input  logic        strm_empty,
  output logic        strm_rd_en,
  output logic [23:0] pixel_data,
  output logic [1:0]  active_src,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  output logic [15:0] frame_cnt,
  input  logic        clr_status
);

  localparam int unsigned POS_W = 13;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned BAR_W = (H_DISP >= 8) ? (H_DISP / 8) : 1;

  localparam logic [SRC_W-1:0] SRC_BARS  = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_STRM  = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_SOLID = SRC_W'(2);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    UNDERRUN = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  state_t              eff_state;
  logic                vs_q;
  logic                sof_c;
  logic                req_c;
  logic                ur_evt_c;
  logic [POS_W-1:0]    bar_div_c;
  logic [2:0]          bar_idx_c;
  logic [SRC_W-1:0]    src_d;
  logic [RGB_W-1:0]    pix_d;
  logic                ur_d;
  logic [CNT_W-1:0]    ur_cnt_d;
  logic [CNT_W-1:0]    frm_d;

  function automatic logic [RGB_W-1:0] bar_rgb(input logic [2:0] idx);
    logic [RGB_W-1:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  // SOF is masked during reset so a low vsync cannot open a pop window while held in reset
  assign sof_c = sys_rst_n & vs_q & ~video_vs;

  // Requests outside the active window are ignored
  assign req_c = data_req && (pixel_ypos != '0) && (32'(pixel_ypos) <= V_DISP);

  assign bar_div_c = pixel_xpos / POS_W'(BAR_W);
  assign bar_idx_c = (bar_div_c > POS_W'(7)) ? 3'd7 : bar_div_c[2:0];

  // Next-state, next-output and FIFO pop decode
  always_comb begin
    state_d    = state_q;
    src_d      = active_src;
    pix_d      = pixel_data;
    ur_d       = underrun;
    ur_cnt_d   = underrun_cnt;
    frm_d      = frame_cnt;
    strm_rd_en = 1'b0;
    ur_evt_c   = 1'b0;
    eff_state  = state_q;

    if (sof_c) begin
      src_d     = (src_sel == SRC_W'(3)) ? SRC_SOLID : src_sel;
      frm_d     = frame_cnt + CNT_W'(1);
      state_d   = RUN;
      eff_state = RUN;
    end

    if (req_c) begin
      unique case (eff_state)
        WAIT_SOF: pix_d = '0;
        RUN: begin
          if (src_d == SRC_BARS) begin
            pix_d = bar_rgb(bar_idx_c);
          end else if (src_d == SRC_STRM) begin
            if (strm_empty) begin
              ur_evt_c = 1'b1;
              pix_d    = FILL_RGB;
              state_d  = UNDERRUN;
            end else begin
              strm_rd_en = 1'b1;
              pix_d      = strm_data;
            end
          end else begin
            pix_d = solid_rgb;
          end
        end
        UNDERRUN: pix_d = FILL_RGB;
        default:  pix_d = '0;
      endcase
    end

    // Only one event per frame is possible since UNDERRUN is left only on SOF
    if (ur_evt_c) begin
      ur_d = 1'b1;
      if (underrun_cnt != '1) begin
        ur_cnt_d = underrun_cnt + CNT_W'(1);
      end
    end

    if (clr_status) begin
      ur_d     = 1'b0;
      ur_cnt_d = '0;
    end
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= WAIT_SOF;
      vs_q         <= 1'b1;
      active_src   <= '0;
      pixel_data   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= video_vs;
      active_src   <= src_d;
      pixel_data   <= pix_d;
      underrun     <= ur_d;
      underrun_cnt <= ur_cnt_d;
      frame_cnt    <= frm_d;
    end
  end

endmodule

// File: tb/tb_video_src_sched.sv
// Directed bench for video_src_sched: driver queues expected pixels, a monitor checks
// each one a cycle after its request, and a small FIFO model feeds the stream port.
module tb_video_src_sched;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        data_req = 1'b0;
  logic [12:0] pixel_xpos = '0;
  logic [12:0] pixel_ypos = '0;
  logic        video_vs = 1'b1;
  logic [1:0]  src_sel = '0;
  logic [23:0] solid_rgb = '0;
  logic [23:0] strm_data = '0;
  logic        strm_empty = 1'b1;
  logic        strm_rd_en;
  logic [23:0] pixel_data;
  logic [1:0]  active_src;
  logic        underrun;
  logic [15:0] underrun_cnt;
  logic [15:0] frame_cnt;
  logic        clr_status = 1'b0;

  localparam logic [23:0] FILL = 24'h0000FF;

  int n_cmp = 0;
  int n_bad = 0;
  int pops = 0;
  logic [23:0] exp_q[$];
  string       tag_q[$];
  logic [23:0] fifo[$];

  video_src_sched dut (
    .pixel_clk    (pixel_clk),
    .sys_rst_n    (sys_rst_n),
    .data_req     (data_req),
    .pixel_xpos   (pixel_xpos),
    .pixel_ypos   (pixel_ypos),
    .video_vs     (video_vs),
    .src_sel      (src_sel),
    .solid_rgb    (solid_rgb),
    .strm_data    (strm_data),
    .strm_empty   (strm_empty),
    .strm_rd_en   (strm_rd_en),
    .pixel_data   (pixel_data),
    .active_src   (active_src),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .frame_cnt    (frame_cnt),
    .clr_status   (clr_status)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Show-ahead FIFO model
  always @(posedge pixel_clk) begin
    if (strm_rd_en) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      pops <= pops + 1;
    end
    strm_empty <= (fifo.size() == 0);
    strm_data  <= (fifo.size() != 0) ? fifo[0] : 24'h0;
  end

  // Monitor: every accepted request must produce its queued pixel one cycle later
  initial begin
    logic hit;
    logic [23:0] e;
    string t;
    forever begin
      @(posedge pixel_clk);
      hit = data_req && sys_rst_n;
      #1;
      if (hit) begin
        if (exp_q.size() == 0) begin
          chk("pixel_unexpected", 32'(pixel_data), 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          chk(t, 32'(pixel_data), 32'(e));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] e, input string tag);
    data_req   = 1'b1;
    pixel_xpos = 13'(x);
    pixel_ypos = 13'(y);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge pixel_clk);
    data_req = 1'b0;
  endtask

  task automatic sof();
    video_vs = 1'b0;
    @(negedge pixel_clk);
    video_vs = 1'b1;
    @(negedge pixel_clk);
  endtask

  task automatic preload(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) fifo.push_back(base + 24'(i));
    @(negedge pixel_clk);
  endtask

  initial begin
    int p0;
    // Reset state
    cyc(2);
    chk("rst_pixel_data", 32'(pixel_data), 32'h0);
    chk("rst_active_src", 32'(active_src), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_underrun_cnt", 32'(underrun_cnt), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_strm_rd_en", 32'(strm_rd_en), 32'h0);
    sys_rst_n = 1'b1;
    cyc(1);

    // Black before first SOF regardless of source selection
    src_sel = 2'd2; solid_rgb = 24'h777777;
    pix(0, 1, 24'h000000, "pre_sof_black");

    // Frame 1: colour bars at H_DISP=3840 (bar width 480)
    src_sel = 2'd0;
    sof();
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_active_src", 32'(active_src), 32'd0);
    pix(0,    1, 24'hFFFFFF, "bar_x0");
    pix(479,  1, 24'hFFFFFF, "bar_x479");
    pix(480,  1, 24'hFFFF00, "bar_x480");
    pix(960,  1, 24'h00FFFF, "bar_x960");
    pix(1919, 1, 24'h00FF00, "bar_x1919");
    pix(1920, 1, 24'hFF00FF, "bar_x1920");
    pix(2400, 1, 24'hFF0000, "bar_x2400");
    pix(2880, 1, 24'h0000FF, "bar_x2880");
    pix(3839, 1, 24'h000000, "bar_x3839");
    pix(4000, 1, 24'h000000, "bar_clamp");

    // Source change mid-frame waits for SOF
    src_sel = 2'd2; solid_rgb = 24'h123456;
    pix(480, 2, 24'hFFFF00, "bar_after_sel_change");
    chk("midframe_active_src", 32'(active_src), 32'd0);

    // Frame 2: solid, sampled per pixel
    sof();
    chk("f2_active_src", 32'(active_src), 32'd2);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
    pix(0, 1, 24'h123456, "solid_first");
    solid_rgb = 24'hABCDEF;
    pix(5, 1, 24'hABCDEF, "solid_resampled");

    // Frame 3: src_sel=3 maps to solid, SOF coincident with a request
    src_sel = 2'd3; solid_rgb = 24'h111111;
    video_vs = 1'b0;
    pix(0, 1, 24'h111111, "sof_coincident_pixel");
    video_vs = 1'b1;
    chk("f3_active_src", 32'(active_src), 32'd2);
    chk("f3_frame_cnt", 32'(frame_cnt), 32'd3);

    // Frame 4: full stream frame (6 lines x 128 pixels)
    src_sel = 2'd1;
    preload(768, 24'h100000);
    p0 = pops;
    sof();
    for (int k = 0; k < 768; k++) pix(k % 128, 1 + k / 128, 24'h100000 + 24'(k), "strm_word");
    cyc(2);
    chk("f4_pops", 32'(pops - p0), 32'd768);
    chk("f4_underrun", 32'(underrun), 32'd0);
    chk("f4_active_src", 32'(active_src), 32'd1);

    // Frame 5: FIFO runs dry at pixel 100 of line 5
    preload(4 * 128 + 100, 24'h200000);
    p0 = pops;
    sof();
    for (int k = 0; k < 768; k++)
      pix(k % 128, 1 + k / 128, (k < 612) ? (24'h200000 + 24'(k)) : FILL, "strm_underrun");
    cyc(2);
    chk("f5_pops", 32'(pops - p0), 32'd612);
    chk("f5_underrun", 32'(underrun), 32'd1);
    chk("f5_underrun_cnt", 32'(underrun_cnt), 32'd1);

    // Frame 6: refilled, stream resumes
    preload(20, 24'h280000);
    sof();
    for (int k = 0; k < 20; k++) pix(k, 1, 24'h280000 + 24'(k), "strm_refill");
    chk("f6_underrun_cnt", 32'(underrun_cnt), 32'd1);
    chk("f6_frame_cnt", 32'(frame_cnt), 32'd6);

    // Frames 7-9: one underrun per frame, second request in same frame not counted
    for (int f = 0; f < 3; f++) begin
      sof();
      pix(0, 1, FILL, "ur_frame_fill");
      pix(1, 1, FILL, "ur_frame_fill2");
      chk("ur_cnt_step", 32'(underrun_cnt), 32'(2 + f));
    end

    // Frame 10: clear coincides with an underrun event
    sof();
    clr_status = 1'b1;
    pix(0, 1, FILL, "ur_clr_fill");
    clr_status = 1'b0;
    chk("clr_underrun", 32'(underrun), 32'd0);
    chk("clr_underrun_cnt", 32'(underrun_cnt), 32'd0);
    pix(1, 1, FILL, "ur_after_clr");
    chk("after_clr_cnt", 32'(underrun_cnt), 32'd0);
    chk("f10_frame_cnt", 32'(frame_cnt), 32'd10);

    // Frame 11: reset during an active stream line
    preload(50, 24'h300000);
    sof();
    for (int k = 0; k < 10; k++) pix(k, 1, 24'h300000 + 24'(k), "strm_pre_reset");
    sys_rst_n = 1'b0;
    data_req  = 1'b1;
    #1;
    chk("rst_mid_pixel_data", 32'(pixel_data), 32'h0);
    chk("rst_mid_strm_rd_en", 32'(strm_rd_en), 32'h0);
    chk("rst_mid_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_mid_active_src", 32'(active_src), 32'h0);
    p0 = pops;
    cyc(3);
    data_req  = 1'b0;
    sys_rst_n = 1'b1;
    cyc(1);
    pix(3, 1, 24'h000000, "post_reset_black");
    chk("rst_no_pops", 32'(pops - p0), 32'd0);
    sof();
    chk("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("post_reset_active_src", 32'(active_src), 32'd1);
    for (int k = 0; k < 5; k++) pix(k, 1, 24'h300000 + 24'(10 + k), "strm_post_reset");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
